// File: rtl/slr_xing_rx.sv
// slr_xing_rx: receive end of a credit-flow-controlled inter-SLR valid/data crossing
//   Ports:
//     sys_clk, sys_rst       : single clock, synchronous active-high reset
//     xin_valid, xin_data    : words arriving from the crossing pipeline (no backpressure)
//     xcr_ret                : registered credit pulse, one per word popped downstream
//     m_axis_tvalid/tdata    : AXI4-Stream master, first-word fall-through
//     m_axis_tready          : AXI4-Stream ready
//     level                  : buffer occupancy, 0..CREDITS
//     ovf                    : sticky flag, word landed while full with no pop
//   Optional feature: define SLR_XING_RX_IN_REG_EN to capture the inputs in a
//   landing register (meant for the SLR-boundary flops), adding one cycle of latency.
module slr_xing_rx #(
   parameter int DATA_W  = 512,
   parameter int CREDITS = 16,
   parameter int LVL_W   = $clog2(CREDITS) + 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              xin_valid,
   input  logic [DATA_W-1:0] xin_data,
   output logic              xcr_ret,
   output logic              m_axis_tvalid,
   output logic [DATA_W-1:0] m_axis_tdata,
   input  logic              m_axis_tready,
   output logic [LVL_W-1:0]  level,
   output logic              ovf
);
   localparam int AW = LVL_W - 1;
   logic              lv;
   logic [DATA_W-1:0] ld;
`ifdef SLR_XING_RX_IN_REG_EN
   logic              lv_q, lv_d;
   logic [DATA_W-1:0] ld_q, ld_d;
   always_comb begin
      lv_d = xin_valid;
      ld_d = xin_data;
   end
   // Only the valid is reset: an in-flight word is lost on reset, data is don't-care.
   always_ff @(posedge sys_clk) begin
      lv_q <= sys_rst ? 1'b0 : lv_d;
      ld_q <= ld_d;
   end
   assign lv = lv_q;
   assign ld = ld_q;
`else
   assign lv = xin_valid;
   assign ld = xin_data;
`endif
   logic [DATA_W-1:0] mem [CREDITS];
   logic [LVL_W-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic              ovf_q, ovf_d, ret_q, ret_d;
   logic              empty, full, pop, wr;
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   // A pop in the same cycle frees a slot, so a landed word is accepted even at full.
   always_comb begin
      empty = wp_q == rp_q;
      full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
      pop   = !empty && m_axis_tready;
      wr    = lv && (!full || pop);
      wp_d  = wp_q + LVL_W'(wr);
      rp_d  = rp_q + LVL_W'(pop);
      ovf_d = ovf_q || (lv && !wr);
      ret_d = pop;
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         ovf_q <= 1'b0;
         ret_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         ovf_q <= ovf_d;
         ret_q <= ret_d;
      end
   end
   // Read is combinational, so at full a simultaneous pop still sees the old slot contents.
   always_ff @(posedge sys_clk) begin
      if (wr) mem[wp_q[AW-1:0]] <= ld;
   end
   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = mem[rp_q[AW-1:0]];
   assign level         = wp_q - rp_q;
   assign ovf           = ovf_q;
   assign xcr_ret       = ret_q;
endmodule

// File: doc/slr_xing_rx.md
# slr_xing_rx

Receive end of the inter-SLR streaming link that carries data between `slr0_top`, `slr1_top` and `slr2_top` through the `pipe_slr*_slr*` crossing registers. The crossing carries valid/data only, with no backpressure, so flow control is credit-based:

- The transmitter in the source SLR sends only while it holds credits.
- This block lands each word in a local buffer of `CREDITS` entries.
- It presents the buffered words as an AXI4-Stream master.
- It returns one credit pulse across the crossing for every word consumed downstream.

## Interface

Parameters:
- `DATA_W`, default 512: payload width in bits.
- `CREDITS`, default 16: buffer depth, equal to the transmitter's initial credit count. Must be a power of two, ≥ 4.
- `LVL_W`, default `$clog2(CREDITS)+1`: width of the occupancy output. Derived, not to be overridden.

Ports:
- `sys_clk`, input, 1: single clock. All logic in this block is synchronous to it.
- `sys_rst`, input, 1: synchronous, active-high reset.
- `xin_valid`, input, 1: word present on `xin_data`, arriving from the crossing pipeline.
- `xin_data`, input, `DATA_W`: crossing payload.
- `xcr_ret`, output, 1: credit-return pulse to the transmitter. One cycle high per freed entry.
- `m_axis_tvalid`, output, 1: AXI4-Stream valid.
- `m_axis_tdata`, output, `DATA_W`: AXI4-Stream data.
- `m_axis_tready`, input, 1: AXI4-Stream ready.
- `level`, output, `LVL_W`: current buffer occupancy, 0..`CREDITS`.
- `ovf`, output, 1: sticky overflow flag, indicating a credit-protocol violation.

## Operation

Buffer:
- Circular memory of `CREDITS` × `DATA_W`.
- Write pointer `wp` and read pointer `rp` are `LVL_W` bits wide. The MSB is the wrap bit.
- Empty when `wp == rp`.
- Full when the low bits are equal and the MSBs differ.
- `level = wp - rp`, computed modulo 2^`LVL_W`.

Write (landed word, "lv"):
- When lv is high and the buffer is not full, or a pop occurs in the same cycle: write `mem[wp]` and increment `wp`.
- When lv is high, the buffer is full, and no pop occurs that cycle: drop the word, set `ovf`, leave `wp` unchanged.
- `ovf` clears only on `sys_rst`.

Read:
- `m_axis_tvalid = !empty`.
- `m_axis_tdata = mem[rp]`, first-word fall-through.
- A pop occurs when `m_axis_tvalid && m_axis_tready`. On a pop, increment `rp`.
- `m_axis_tdata` must remain stable while `m_axis_tvalid` is high and `m_axis_tready` is low.

Credit return:
- `xcr_ret` is registered and equals the previous cycle's pop.
- Exactly one pulse per popped word.
- Dropped words generate no credit.

Simultaneous write and pop:
- Both take effect in the same cycle and `level` is unchanged.
- At full, the incoming word occupies the slot being vacated, and the popped data is the old contents of that slot.

Reset:
- On reset: `wp = rp = 0`, `ovf = 0`, `xcr_ret = 0`. Therefore `m_axis_tvalid = 0` and `level = 0`.
- Memory contents need no reset.
- Reset mid-stream discards all buffered words and returns no credits for them. The transmitter is reset by the same `sys_rst` and reloads `CREDITS`.
- Any landing-register stage is cleared, so an in-flight word is lost.

No state machine beyond the pointer pair. The block must not stall or throttle the input.

## Timing

- Input to output without `SLR_XING_RX_IN_REG_EN`: `xin_valid` high in cycle N gives `m_axis_tvalid` high in cycle N+1 if the buffer was empty.
- With `SLR_XING_RX_IN_REG_EN`: cycle N+2.
- Pop to credit: pop in cycle M gives `xcr_ret` high in cycle M+1.
- `level` and `ovf` are registered state, updated at the edge ending the write or pop cycle.
- Throughput: one word per cycle sustained in and out.
- Round-trip credit loop: the full rate is sustained only if `CREDITS` ≥ crossing latency plus block latency plus credit-return latency. This sizing is the integrator's responsibility.

## Configuration

- Macro `SLR_XING_RX_IN_REG_EN`.
- Defined: `xin_valid` and `xin_data` are captured in a landing register before the buffer write, to be placed on the Laguna/SLR-boundary flops. That register's valid resets to 0. Latency is +1 cycle, with no other behavioural change.
- Undefined: the inputs feed the write port directly.

## Test plan

- Single word: after reset, `xin_valid=1` with `xin_data=0xA5` for one cycle, `m_axis_tready=1`. Expect `m_axis_tvalid` high for exactly 1 cycle at N+1 (N+2 with the macro) with data 0xA5, then `xcr_ret` high 1 cycle later, `level` back to 0.
- Fill/drain: 16 consecutive words 0..15 with `m_axis_tready=0`. Expect `level=16`, `ovf=0`, no `xcr_ret`. Then hold ready high: words emerge in order 0..15 on consecutive cycles, followed by 16 `xcr_ret` pulses each one cycle behind its pop.
- Overflow: at `level=16`, ready low, drive a 17th word 0xFF. Expect it dropped, `ovf=1` sticky, `level=16`, and output order still 0..15.
- Full with simultaneous pop: at `level=16`, ready high and `xin_valid=1` with 0x77 in the same cycle. Expect word 0 popped, `level` stays 16, `ovf=0`, and 0x77 emerges after word 15.
- Backpressure stability: random `m_axis_tready` with 1000 streamed words under correct credit use. Expect in-order data, stable `m_axis_tdata` while stalled, `xcr_ret` count equal to the pop count, `ovf=0`.
- Mid-stream reset: `sys_rst` high for 1 cycle at `level=5`. Expect the next cycle `level=0`, `m_axis_tvalid=0`, `ovf=0`, `xcr_ret=0`, with no credits returned for the 5 discarded words.
